// File: rtl/mandelbrot_pixel_engine.sv
// Mandelbrot pixel engine: walks a frame in raster order and iterates
// z <- z^2 + c for each pixel, emitting the escape iteration per pixel
// through a valid/ready handshake.
//
// state | meaning
// IDLE  | waiting for a frame request
// INIT  | load c for the current pixel, clear z and n
// ITER  | one z^2 + c step per cycle, escape/limit test
// OUT   | result presented, waiting for downstream accept
// DONE  | one-cycle end-of-frame pulse

module mandelbrot_pixel_engine #(
   parameter int DATA_W = 32,
   parameter int FRAC_W = 28,
   parameter int CNT_W  = 10,
   parameter int ITER_W = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     en,
   input  logic                     start,
   input  logic [CNT_W-1:0]         x_size,
   input  logic [CNT_W-1:0]         y_size,
   input  logic signed [DATA_W-1:0] re_min,
   input  logic signed [DATA_W-1:0] im_max,
   input  logic signed [DATA_W-1:0] delta,
   input  logic [ITER_W-1:0]        max_iter,
   output logic                     busy,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [CNT_W-1:0]         px_x,
   output logic [CNT_W-1:0]         px_y,
   output logic [ITER_W-1:0]        iter_count,
   output logic                     frame_done
);

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      INIT = 3'd1,
      ITER = 3'd2,
      OUT  = 3'd3,
      DONE = 3'd4
   } state_t;

   // Escape threshold 4.0, held one bit wider than the product so the
   // magnitude sum never wraps before the compare.
   localparam logic signed [2*DATA_W:0] ESC_LIM =
      {{(2*DATA_W-2){1'b0}}, 3'd4} << FRAC_W;

   state_t state, state_nx;

   logic [CNT_W-1:0]         xs_q, ys_q, x_q, y_q;
   logic [ITER_W-1:0]        mi_q, n_q, iter_q;
   logic signed [DATA_W-1:0] re_min_q, delta_q;
   logic signed [DATA_W-1:0] acc_re, acc_im;
   logic signed [DATA_W-1:0] c_re, c_im, z_re, z_im;

   logic signed [2*DATA_W-1:0] z_re_x, z_im_x, c_re_x, c_im_x;
   logic signed [2*DATA_W-1:0] prod_rr, prod_ii, prod_ri;
   logic signed [2*DATA_W-1:0] zr2, zi2, zri;
   logic signed [2*DATA_W-1:0] nz_re, nz_im;
   logic signed [2*DATA_W:0]   mag;
   logic                       escape, iter_done, x_last, last_px;
   logic                       unused_hi;

   // Complex-square datapath at full product width
   always_comb begin
      z_re_x  = $signed({{DATA_W{z_re[DATA_W-1]}}, z_re});
      z_im_x  = $signed({{DATA_W{z_im[DATA_W-1]}}, z_im});
      c_re_x  = $signed({{DATA_W{c_re[DATA_W-1]}}, c_re});
      c_im_x  = $signed({{DATA_W{c_im[DATA_W-1]}}, c_im});
      prod_rr = z_re_x * z_re_x;
      prod_ii = z_im_x * z_im_x;
      prod_ri = z_re_x * z_im_x;
      zr2     = prod_rr >>> FRAC_W;
      zi2     = prod_ii >>> FRAC_W;
      zri     = prod_ri >>> FRAC_W;
      mag     = $signed({zr2[2*DATA_W-1], zr2}) + $signed({zi2[2*DATA_W-1], zi2});
      escape  = mag > ESC_LIM;
      nz_re   = zr2 - zi2 + c_re_x;
      nz_im   = (zri <<< 1) + c_im_x;
      iter_done = escape || (n_q == mi_q);
      x_last  = (x_q == xs_q - CNT_W'(1));
      last_px = x_last && (y_q == ys_q - CNT_W'(1));
   end

   // The new z is deliberately truncated to DATA_W; upper bits are dropped
   assign unused_hi = ^{nz_re[2*DATA_W-1:DATA_W], nz_im[2*DATA_W-1:DATA_W]};

   // Next-state and status outputs
   always_comb begin
      state_nx   = state;
      busy       = 1'b0;
      out_valid  = 1'b0;
      frame_done = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               state_nx = ((x_size == '0) || (y_size == '0)) ? DONE : INIT;
            end
         end
         INIT: begin
            busy     = 1'b1;
            state_nx = ITER;
         end
         ITER: begin
            busy = 1'b1;
            if (iter_done) begin
               state_nx = OUT;
            end
         end
         OUT: begin
            busy      = 1'b1;
            out_valid = 1'b1;
            if (out_ready) begin
               state_nx = last_px ? DONE : INIT;
            end
         end
         DONE: begin
            frame_done = 1'b1;
            state_nx   = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else if (en) begin
         state <= state_nx;
      end
   end

   // Configuration capture, pixel walk and iteration registers
   always_ff @(posedge clk) begin
      if (rst) begin
         xs_q     <= '0;
         ys_q     <= '0;
         x_q      <= '0;
         y_q      <= '0;
         mi_q     <= '0;
         n_q      <= '0;
         iter_q   <= '0;
         re_min_q <= '0;
         delta_q  <= '0;
         acc_re   <= '0;
         acc_im   <= '0;
         c_re     <= '0;
         c_im     <= '0;
         z_re     <= '0;
         z_im     <= '0;
      end else if (en) begin
         case (state)
            IDLE: begin
               if (start) begin
                  xs_q     <= x_size;
                  ys_q     <= y_size;
                  mi_q     <= max_iter;
                  re_min_q <= re_min;
                  delta_q  <= delta;
                  acc_re   <= re_min;
                  acc_im   <= im_max;
                  x_q      <= '0;
                  y_q      <= '0;
               end
            end
            INIT: begin
               c_re <= acc_re;
               c_im <= acc_im;
               z_re <= '0;
               z_im <= '0;
               n_q  <= '0;
            end
            ITER: begin
               if (iter_done) begin
                  iter_q <= n_q;
               end else begin
                  z_re <= nz_re[DATA_W-1:0];
                  z_im <= nz_im[DATA_W-1:0];
                  n_q  <= n_q + ITER_W'(1);
               end
            end
            OUT: begin
               // c advances incrementally so no multiplier is needed for x*delta
               if (out_ready && !last_px) begin
                  if (x_last) begin
                     x_q    <= '0;
                     y_q    <= y_q + CNT_W'(1);
                     acc_re <= re_min_q;
                     acc_im <= acc_im - delta_q;
                  end else begin
                     x_q    <= x_q + CNT_W'(1);
                     acc_re <= acc_re + delta_q;
                  end
               end
            end
            default: ;
         endcase
      end
   end

   assign px_x       = x_q;
   assign px_y       = y_q;
   assign iter_count = iter_q;

endmodule

// File: tb/tb_mandelbrot_pixel_engine.sv
// Directed bench for mandelbrot_pixel_engine; all activity on the falling edge.

module tb_mandelbrot_pixel_engine;

   logic        clk = 1'b0;
   logic        rst, en, start, out_ready;
   logic [9:0]  x_size, y_size;
   logic signed [31:0] re_min, im_max, delta;
   logic [7:0]  max_iter;
   logic        busy, out_valid, frame_done;
   logic [9:0]  px_x, px_y;
   logic [7:0]  iter_count;

   int checks = 0;
   int passed = 0;

   mandelbrot_pixel_engine dut (
      .clk        (clk),
      .rst        (rst),
      .en         (en),
      .start      (start),
      .x_size     (x_size),
      .y_size     (y_size),
      .re_min     (re_min),
      .im_max     (im_max),
      .delta      (delta),
      .max_iter   (max_iter),
      .busy       (busy),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .px_x       (px_x),
      .px_y       (px_y),
      .iter_count (iter_count),
      .frame_done (frame_done)
   );

   always #5 clk = ~clk;

   // Called at a falling edge; returns at the falling edge of cycle t+1.
   task automatic do_start(input int xs, input int ys, input logic [31:0] re,
                           input logic [31:0] im, input logic [31:0] d, input int mi);
      x_size   = 10'(xs);
      y_size   = 10'(ys);
      re_min   = re;
      im_max   = im;
      delta    = d;
      max_iter = 8'(mi);
      start    = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start    = 1'b0;
   endtask

   task automatic test_reset;
      rst = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      checks++;
      if ({busy, out_valid, frame_done, px_x, px_y, iter_count} !== 31'd0)
         $display("FAIL reset_outputs got busy=%0d valid=%0d done=%0d x=%0d y=%0d it=%0d exp all 0",
                  busy, out_valid, frame_done, px_x, px_y, iter_count);
      else passed++;
   endtask

   task automatic test_origin;
      int cyc;
      do_start(1, 1, 32'h0, 32'h0, 32'h1000_0000, 5);
      cyc = 1;
      checks++;
      if (busy !== 1'b1) $display("FAIL origin_busy got=%0d exp=1", busy); else passed++;
      while (!out_valid && cyc < 100) begin @(negedge clk); cyc++; end
      checks++;
      if (cyc !== 8) $display("FAIL origin_latency got=%0d exp=8", cyc); else passed++;
      checks++;
      if (iter_count !== 8'd5) $display("FAIL origin_iter got=%0d exp=5", iter_count); else passed++;
      checks++;
      if (px_x !== 10'd0 || px_y !== 10'd0)
         $display("FAIL origin_coord got=(%0d,%0d) exp=(0,0)", px_x, px_y);
      else passed++;
      @(negedge clk);
      checks++;
      if (frame_done !== 1'b1 || out_valid !== 1'b0)
         $display("FAIL origin_done got done=%0d valid=%0d exp done=1 valid=0", frame_done, out_valid);
      else passed++;
      @(negedge clk);
      checks++;
      if (frame_done !== 1'b0 || busy !== 1'b0)
         $display("FAIL origin_idle got done=%0d busy=%0d exp 0 0", frame_done, busy);
      else passed++;
   endtask

   task automatic test_escape_two;
      int cyc;
      do_start(1, 1, 32'h2000_0000, 32'h0, 32'h1000_0000, 50);
      cyc = 1;
      while (!out_valid && cyc < 200) begin @(negedge clk); cyc++; end
      checks++;
      if (cyc !== 5) $display("FAIL escape_latency got=%0d exp=5", cyc); else passed++;
      checks++;
      if (iter_count !== 8'd2) $display("FAIL escape_iter got=%0d exp=2", iter_count); else passed++;
      repeat (3) @(negedge clk);
   endtask

   task automatic test_raster;
      int cyc, dones, extra;
      int row1_it[4] = '{20, 20, 20, 5};
      do_start(4, 2, 32'hF000_0000, 32'h0800_0000, 32'h0800_0000, 20);
      for (int p = 0; p < 8; p++) begin
         cyc = 0;
         while (!out_valid && cyc < 300) begin @(negedge clk); cyc++; end
         checks++;
         if (!out_valid) $display("FAIL raster_timeout pixel=%0d got valid=0 exp=1", p);
         else passed++;
         checks++;
         if (px_x !== 10'(p % 4) || px_y !== 10'(p / 4))
            $display("FAIL raster_coord pixel=%0d got=(%0d,%0d) exp=(%0d,%0d)",
                     p, px_x, px_y, p % 4, p / 4);
         else passed++;
         if (p >= 4) begin
            checks++;
            if (iter_count !== 8'(row1_it[p-4]))
               $display("FAIL raster_iter pixel=%0d got=%0d exp=%0d", p, iter_count, row1_it[p-4]);
            else passed++;
         end
         @(negedge clk);
      end
      dones = 0;
      extra = 0;
      for (int i = 0; i < 10; i++) begin
         if (frame_done) dones++;
         if (out_valid) extra++;
         @(negedge clk);
      end
      checks++;
      if (dones !== 1) $display("FAIL raster_done_pulses got=%0d exp=1", dones); else passed++;
      checks++;
      if (extra !== 0) $display("FAIL raster_extra_valid got=%0d exp=0", extra); else passed++;
   endtask

   task automatic test_backpressure;
      int cyc, extra;
      out_ready = 1'b0;
      do_start(1, 1, 32'h0, 32'h0, 32'h1000_0000, 3);
      cyc = 1;
      while (!out_valid && cyc < 100) begin @(negedge clk); cyc++; end
      checks++;
      if (cyc !== 6) $display("FAIL stall_latency got=%0d exp=6", cyc); else passed++;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         checks++;
         if (out_valid !== 1'b1 || iter_count !== 8'd3 || px_x !== 10'd0 || px_y !== 10'd0)
            $display("FAIL stall_hold cycle=%0d got valid=%0d it=%0d x=%0d y=%0d exp 1 3 0 0",
                     i, out_valid, iter_count, px_x, px_y);
         else passed++;
         if (i == 4) begin start = 1'b1; x_size = 10'd4; end
         if (i == 5) start = 1'b0;
      end
      out_ready = 1'b1;
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0 || frame_done !== 1'b1)
         $display("FAIL stall_release got valid=%0d done=%0d exp 0 1", out_valid, frame_done);
      else passed++;
      extra = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (out_valid || busy) extra++;
      end
      checks++;
      if (extra !== 0) $display("FAIL stall_start_ignored got=%0d busy/valid cycles exp=0", extra);
      else passed++;
   endtask

   task automatic test_zero_size;
      int dones, vals;
      do_start(0, 3, 32'h0, 32'h0, 32'h1000_0000, 5);
      checks++;
      if (frame_done !== 1'b1) $display("FAIL zero_done got=%0d exp=1", frame_done); else passed++;
      dones = 0;
      vals  = 0;
      for (int i = 0; i < 10; i++) begin
         if (frame_done) dones++;
         if (out_valid) vals++;
         @(negedge clk);
      end
      checks++;
      if (dones !== 1 || vals !== 0)
         $display("FAIL zero_pulses got done=%0d valid=%0d exp 1 0", dones, vals);
      else passed++;
   endtask

   task automatic test_enable_freeze;
      int cyc;
      do_start(1, 1, 32'h0, 32'h0, 32'h1000_0000, 5);
      cyc = 1;
      en  = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         cyc++;
         checks++;
         if (busy !== 1'b1 || out_valid !== 1'b0)
            $display("FAIL freeze_hold cycle=%0d got busy=%0d valid=%0d exp 1 0", i, busy, out_valid);
         else passed++;
      end
      en = 1'b1;
      while (!out_valid && cyc < 100) begin @(negedge clk); cyc++; end
      checks++;
      if (cyc !== 13 || iter_count !== 8'd5)
         $display("FAIL freeze_latency got cyc=%0d it=%0d exp 13 5", cyc, iter_count);
      else passed++;
      repeat (3) @(negedge clk);
   endtask

   task automatic test_reset_midframe;
      int cyc, bad, dones;
      do_start(4, 2, 32'hF000_0000, 32'h0800_0000, 32'h0800_0000, 20);
      for (int p = 0; p < 3; p++) begin
         cyc = 0;
         while (!out_valid && cyc < 300) begin @(negedge clk); cyc++; end
         @(negedge clk);
      end
      @(negedge clk);
      checks++;
      if (px_x !== 10'd3 || busy !== 1'b1)
         $display("FAIL midrst_setup got x=%0d busy=%0d exp 3 1", px_x, busy);
      else passed++;
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      checks++;
      if ({busy, out_valid, frame_done, px_x, px_y, iter_count} !== 31'd0)
         $display("FAIL midrst_outputs got busy=%0d valid=%0d done=%0d x=%0d y=%0d it=%0d exp all 0",
                  busy, out_valid, frame_done, px_x, px_y, iter_count);
      else passed++;
      bad = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (out_valid || frame_done || busy) bad++;
      end
      checks++;
      if (bad !== 0) $display("FAIL midrst_residue got=%0d active cycles exp=0", bad); else passed++;
      do_start(2, 1, 32'h0, 32'h0, 32'h1000_0000, 4);
      for (int p = 0; p < 2; p++) begin
         cyc = 0;
         while (!out_valid && cyc < 100) begin @(negedge clk); cyc++; end
         checks++;
         if (!out_valid || px_x !== 10'(p) || px_y !== 10'd0)
            $display("FAIL midrst_refresh pixel=%0d got valid=%0d (%0d,%0d) exp 1 (%0d,0)",
                     p, out_valid, px_x, px_y, p);
         else passed++;
         @(negedge clk);
      end
      dones = 0;
      for (int i = 0; i < 5; i++) begin
         if (frame_done) dones++;
         @(negedge clk);
      end
      checks++;
      if (dones !== 1) $display("FAIL midrst_done got=%0d exp=1", dones); else passed++;
   endtask

   initial begin
      rst       = 1'b1;
      en        = 1'b1;
      start     = 1'b0;
      out_ready = 1'b1;
      x_size    = '0;
      y_size    = '0;
      re_min    = '0;
      im_max    = '0;
      delta     = '0;
      max_iter  = '0;
      @(negedge clk);
      test_reset;
      test_origin;
      test_escape_two;
      test_raster;
      test_backpressure;
      test_zero_size;
      test_enable_freeze;
      test_reset_midframe;
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule

// File: doc/mandelbrot_pixel_engine.md
MANDELBROT_PIXEL_ENGINE -- requirements
Module: mandelbrot_pixel_engine

Interface
REQ-001 SHALL have parameter DATA_W, default 32: width of signed fixed-point operands.
REQ-002 SHALL have parameter FRAC_W, default 28: fraction bits (Q4.28 at defaults).
REQ-003 SHALL have parameter CNT_W, default 10: pixel coordinate counter width.
REQ-004 SHALL have parameter ITER_W, default 8: iteration count width.
REQ-005 SHALL have ports:
- clk  in  1  sole clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- en  in  1  global enable; low freezes all state.
- start  in  1  frame request pulse.
- x_size  in  CNT_W  frame width in pixels.
- y_size  in  CNT_W  frame height in pixels.
- re_min  in  DATA_W  signed real coordinate of column 0.
- im_max  in  DATA_W  signed imaginary coordinate of row 0.
- delta  in  DATA_W  signed pixel pitch, both axes.
- max_iter  in  ITER_W  iteration limit.
- busy  out  1  frame in progress.
- out_valid  out  1  pixel result valid.
- out_ready  in  1  downstream accept.
- px_x  out  CNT_W  result column.
- px_y  out  CNT_W  result row.
- iter_count  out  ITER_W  escape iteration.
- frame_done  out  1  one-cycle end-of-frame pulse.

Function
REQ-006 SHALL implement FSM states IDLE, INIT, ITER, OUT, DONE; when en=0 every register SHALL hold its value.
REQ-007 SHALL, in IDLE with start=1, capture all configuration inputs, clear x,y to 0, set busy=1, and go to INIT; start SHALL be ignored outside IDLE.
REQ-008 SHALL, if the captured x_size or y_size is 0, go directly to DONE with no out_valid.
REQ-009 SHALL, in INIT (one cycle):
- load c_re = re_min + x*delta and c_im = im_max - y*delta, formed by incremental add/subtract of delta as x and y advance, not by multiplication;
- clear z_re, z_im and n to 0.
REQ-010 SHALL, each ITER cycle:
- form zr2 = (z_re*z_re)>>>FRAC_W, zi2 = (z_im*z_im)>>>FRAC_W and zri = (z_re*z_im)>>>FRAC_W from full 2*DATA_W products;
- evaluate the escape test zr2+zi2 > (4<<FRAC_W) at full width, never truncated.
REQ-011 SHALL leave ITER for OUT with iter_count=n when the escape test is true (strict greater-than) or n==max_iter; otherwise it SHALL set z_re = zr2-zi2+c_re and z_im = 2*zri+c_im, both truncated to DATA_W, and increment n.
REQ-012 SHALL, in OUT, hold out_valid=1 with px_x, px_y and iter_count stable until a cycle with out_valid&&out_ready.
REQ-013 SHALL, on that handshake:
- not the last pixel: x wraps from x_size-1 to 0 with y+1, otherwise x+1; next state INIT;
- last pixel (x_size-1, y_size-1): next state DONE.
REQ-014 SHALL, in DONE, assert frame_done for exactly one cycle, clear busy, and return to IDLE.
REQ-015 SHALL have latency, with start accepted at cycle t and out_ready=1: INIT at t+1, ITER at t+2 through t+2+k, out_valid at t+3+k, where k is the final n.
REQ-016 SHALL emit pixels in raster order: x fastest, y slowest.

Reset
REQ-017 SHALL, when rst=1 at a clock edge (including mid-frame, and regardless of en), return the FSM to IDLE with busy=0, out_valid=0, frame_done=0, and px_x, px_y, iter_count, x, y, n, z_re and z_im all 0.
REQ-018 SHALL NOT emit any partial-frame output or frame_done after reset.

Verification
REQ-019 SHALL cover: 1x1 frame, re_min=0, im_max=0, max_iter=5 -> out_valid at t+8, iter_count=5, px_x=0, px_y=0, then frame_done.
REQ-020 SHALL cover: 1x1 frame, re_min=2.0 (0x20000000), im_max=0, max_iter=50 -> iter_count=2 (|z1|^2=4 does not escape; |z2|^2=36 escapes, with no overflow effect on the test).
REQ-021 SHALL cover: 4x2 frame, delta=0.5 -> exactly 8 handshakes with (px_x,px_y) in order (0,0)..(3,0),(0,1)..(3,1), then a single frame_done pulse.
REQ-022 SHALL cover: out_ready held low 10 cycles during OUT -> out_valid remains 1, outputs unchanged, and only one result delivered.
REQ-023 SHALL cover: x_size=0 -> frame_done pulse at t+1 and no out_valid.
REQ-024 SHALL cover: rst pulsed during ITER of pixel 3 of a 4x2 frame -> all outputs 0 the next cycle; a fresh start then produces a complete frame beginning at (0,0).
